// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced buttons with press pulse/toggle/lock, switch sync; auto-repeat under BTN_COND_REPEAT_EN.
// Latency: press = 2 cycles + DEPTH ticks + 1 cycle after a clean step; sw_out 2 cycles.
// Backpressure: none; press is a one-cycle strobe the consumer must catch.
module btn_conditioner #(
    parameter int               N_BTN       = 4,
    parameter int               N_SW        = 2,
    parameter int               DIV_W       = 17,
    parameter int               DEPTH       = 3,
    parameter logic [N_BTN-1:0] TOGGLE_MASK = {N_BTN{1'b0}},
    parameter int               REPEAT_DLY  = 8,
    parameter int               REPEAT_PER  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_SW-1:0]  sw_in,
    input  logic             lock,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_tog,
    output logic [N_SW-1:0]  sw_out
);

    logic [DIV_W-1:0]            div_q, div_d;
    logic                        tick_q, tick_d;
    logic                        eval_q, eval_d;
    logic [N_BTN-1:0]            bsync1_q, bsync1_d, bsync2_q, bsync2_d;
    logic [N_SW-1:0]             ssync1_q, ssync1_d, ssync2_q, ssync2_d;
    logic [N_BTN-1:0][DEPTH-1:0] samp_q, samp_d;
    logic [N_BTN-1:0]            level_q, level_d;
    logic [N_BTN-1:0]            press_q, press_d;
    logic [N_BTN-1:0]            tog_q, tog_d;
`ifdef BTN_COND_REPEAT_EN
    logic [N_BTN-1:0][7:0]       rcnt_q, rcnt_d;
    logic [N_BTN-1:0]            rph_q, rph_d;
`endif

    always_comb begin
        div_d    = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        tick_d   = &div_q;
        // Debounce decisions look at the shift register one cycle after it moved.
        eval_d   = tick_q;
        bsync1_d = btn_in;
        bsync2_d = bsync1_q;
        ssync1_d = sw_in;
        ssync2_d = ssync1_q;
        samp_d   = samp_q;
        level_d  = level_q;
        press_d  = '0;
        tog_d    = tog_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick_q) begin
                samp_d[i] = {samp_q[i][DEPTH-2:0], bsync2_q[i]};
            end
            if (eval_q) begin
                if ((&samp_q[i]) && !level_q[i]) begin
                    level_d[i] = 1'b1;
                    press_d[i] = 1'b1;
                    if (TOGGLE_MASK[i] && !lock) begin
                        tog_d[i] = ~tog_q[i];
                    end
                end else if (~|samp_q[i]) begin
                    level_d[i] = 1'b0;
                end
            end
            if (!TOGGLE_MASK[i]) begin
                tog_d[i] = 1'b0;
            end
        end
`ifdef BTN_COND_REPEAT_EN
        rcnt_d = rcnt_q;
        rph_d  = rph_q;
        // rph marks that the initial delay has elapsed; afterwards the counter wraps every period.
        for (int i = 0; i < N_BTN; i++) begin
            if (!level_q[i] || !level_d[i] || TOGGLE_MASK[i]) begin
                rcnt_d[i] = '0;
                rph_d[i]  = 1'b0;
            end else if (eval_q) begin
                if (!rph_q[i] && ((rcnt_q[i] + 8'd1) == 8'(REPEAT_DLY))) begin
                    press_d[i] = 1'b1;
                    rph_d[i]   = 1'b1;
                    rcnt_d[i]  = '0;
                end else if (rph_q[i] && ((rcnt_q[i] + 8'd1) == 8'(REPEAT_PER))) begin
                    press_d[i] = 1'b1;
                    rcnt_d[i]  = '0;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 8'd1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            eval_q   <= 1'b0;
            bsync1_q <= '0;
            bsync2_q <= '0;
            ssync1_q <= '0;
            ssync2_q <= '0;
            samp_q   <= '0;
            level_q  <= '0;
            press_q  <= '0;
            tog_q    <= '0;
`ifdef BTN_COND_REPEAT_EN
            rcnt_q   <= '0;
            rph_q    <= '0;
`endif
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            eval_q   <= eval_d;
            bsync1_q <= bsync1_d;
            bsync2_q <= bsync2_d;
            ssync1_q <= ssync1_d;
            ssync2_q <= ssync2_d;
            samp_q   <= samp_d;
            level_q  <= level_d;
            press_q  <= press_d;
            tog_q    <= tog_d;
`ifdef BTN_COND_REPEAT_EN
            rcnt_q   <= rcnt_d;
            rph_q    <= rph_d;
`endif
        end
    end

    assign tick      = tick_q;
    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_tog   = tog_q;
    assign sw_out    = ssync2_q;

endmodule
